// File: rtl/main_fsm.sv
// main_fsm: multicycle processor main controller.
// Moore machine: a four-bit state register steps the datapath through
// fetch, decode and the per-class execute sequences. Every control output
// is a pure decode of the state register, so Op/Funct can only influence
// the machine through the next-state logic, and only in DECODE/MEMADR.
module main_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [3:0] State
);

    // State encodings are visible on the debug State port, so they are fixed.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    // Instruction classes carried in Op.
    localparam logic [1:0] OP_DP     = 2'b00;
    localparam logic [1:0] OP_MEM    = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;

    // Operand / result select codes.
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Complete control word driven by the controller.
    typedef struct packed {
        logic       ir_write;
        logic       adr_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       next_pc;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        ir_write:   1'b0,
        adr_src:    1'b0,
        alu_src_a:  1'b0,
        alu_src_b:  2'b00,
        result_src: 2'b00,
        next_pc:    1'b0,
        reg_w:      1'b0,
        mem_w:      1'b0,
        branch:     1'b0,
        alu_op:     1'b0
    };

    // Control word for a given state; unknown encodings produce all zeros
    // so a corrupted state register can never request a write.
    function automatic ctrl_t decode_ctrl(input state_t st);
        ctrl_t c;
        c = CTRL_IDLE;
        case (st)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.next_pc    = 1'b1;
                c.adr_src    = 1'b0;
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.alu_op     = 1'b0;
            end
            S_DECODE: begin
                c.alu_src_a  = 1'b1;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
            end
            S_EXECUTER: begin
                c.alu_src_a  = 1'b0;
                c.alu_src_b  = SRCB_REG;
                c.alu_op     = 1'b1;
            end
            S_EXECUTEI: begin
                c.alu_src_a  = 1'b0;
                c.alu_src_b  = SRCB_IMM;
                c.alu_op     = 1'b1;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_w      = 1'b1;
            end
            S_MEMADR: begin
                c.alu_src_a  = 1'b0;
                c.alu_src_b  = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_w      = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = 1'b0;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALU;
                c.branch     = 1'b1;
            end
            default: begin
                c = CTRL_IDLE;
            end
        endcase
        return c;
    endfunction

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_s;

    // Funct[4:1] select the ALU operation; that decode lives in the ALU decoder.
    logic unused_funct_s;
    assign unused_funct_s = ^Funct[4:1];

    // State register: asynchronous return to FETCH on reset, else advance every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; Op/Funct are only looked at in DECODE and MEMADR.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                case (Op)
                    OP_DP: begin
                        if (Funct[5]) begin
                            next_state_s = S_EXECUTEI;
                        end else begin
                            next_state_s = S_EXECUTER;
                        end
                    end
                    OP_MEM:    next_state_s = S_MEMADR;
                    OP_BRANCH: next_state_s = S_BRANCH;
                    default:   next_state_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Funct[0]) begin
                    next_state_s = S_MEMREAD;
                end else begin
                    next_state_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_state_s = S_MEMWB;
            S_MEMWB:    next_state_s = S_FETCH;
            S_MEMWRITE: next_state_s = S_FETCH;
            S_EXECUTER: next_state_s = S_ALUWB;
            S_EXECUTEI: next_state_s = S_ALUWB;
            S_ALUWB:    next_state_s = S_FETCH;
            S_BRANCH:   next_state_s = S_FETCH;
            default:    next_state_s = S_FETCH;
        endcase
    end

    // Output decode straight from the state register (Moore outputs).
    always_comb begin
        ctrl_s    = decode_ctrl(state_r);
        IRWrite   = ctrl_s.ir_write;
        AdrSrc    = ctrl_s.adr_src;
        ALUSrcA   = ctrl_s.alu_src_a;
        ALUSrcB   = ctrl_s.alu_src_b;
        ResultSrc = ctrl_s.result_src;
        NextPC    = ctrl_s.next_pc;
        RegW      = ctrl_s.reg_w;
        MemW      = ctrl_s.mem_w;
        Branch    = ctrl_s.branch;
        ALUOp     = ctrl_s.alu_op;
        State     = state_r;
    end

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: walks each instruction class through its
// state sequence and checks state and control outputs at every step.
module tb_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       ALUOp;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    main_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .IRWrite   (IRWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .ALUOp     (ALUOp),
        .State     (State)
    );

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary, expected done before 200000");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b1;
        Op    = 2'b00;
        Funct = 6'b000000;
        repeat (3) @(negedge clk);
        total++;
        if (State !== 4'd0) begin
            bad++; $display("FAIL reset_state: got %0d expected 0", State);
        end
        total++;
        if ({IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch}
            !== {1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_ctrl: got IRW=%b NPC=%b Adr=%b A=%b B=%b Res=%b ALUOp=%b RegW=%b MemW=%b Br=%b expected 1 1 0 1 10 10 0 0 0 0",
                IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch);
        end
        reset = 1'b0;
        total++;
        if (State !== 4'd0) begin
            bad++; $display("FAIL reset_release_state: got %0d expected 0", State);
        end
    endtask

    task automatic test_dp_reg();
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        Op = 2'b00; Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL dp_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            total++;
            if (RegW !== (exp[i] == 4'd8)) begin
                bad++; $display("FAIL dp_regw[%0d]: got %b expected %b", i, RegW, (exp[i] == 4'd8));
            end
            if (exp[i] == 4'd6) begin
                total++;
                if ({ALUOp, ALUSrcA, ALUSrcB} !== {1'b1, 1'b0, 2'b00}) begin
                    bad++; $display("FAIL dp_exec_ctrl: got ALUOp=%b A=%b B=%b expected 1 0 00", ALUOp, ALUSrcA, ALUSrcB);
                end
            end
            if (exp[i] == 4'd1) begin
                total++;
                if ({IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc, ALUOp} !== {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0}) begin
                    bad++; $display("FAIL decode_ctrl: got IRW=%b NPC=%b A=%b B=%b Res=%b ALUOp=%b expected 0 0 1 10 10 0",
                        IRWrite, NextPC, ALUSrcA, ALUSrcB, ResultSrc, ALUOp);
                end
            end
        end
    endtask

    task automatic test_load();
        logic [3:0] exp [6];
        exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        Op = 2'b01; Funct = 6'b000001;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL ldr_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            total++;
            if (RegW !== (exp[i] == 4'd4)) begin
                bad++; $display("FAIL ldr_regw[%0d]: got %b expected %b", i, RegW, (exp[i] == 4'd4));
            end
            if (exp[i] == 4'd3) begin
                total++;
                if (AdrSrc !== 1'b1) begin
                    bad++; $display("FAIL ldr_adrsrc: got %b expected 1", AdrSrc);
                end
            end
            if (exp[i] == 4'd4) begin
                total++;
                if (ResultSrc !== 2'b01) begin
                    bad++; $display("FAIL ldr_resultsrc: got %b expected 01", ResultSrc);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        Op = 2'b01; Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL str_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            total++;
            if ({MemW, RegW} !== {(exp[i] == 4'd5), 1'b0}) begin
                bad++; $display("FAIL str_writes[%0d]: got MemW=%b RegW=%b expected %b 0", i, MemW, RegW, (exp[i] == 4'd5));
            end
        end
    endtask

    task automatic test_branch();
        logic [3:0] exp [4];
        exp = '{4'd0, 4'd1, 4'd9, 4'd0};
        Op = 2'b10; Funct = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL br_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            total++;
            if (Branch !== (exp[i] == 4'd9)) begin
                bad++; $display("FAIL br_branch[%0d]: got %b expected %b", i, Branch, (exp[i] == 4'd9));
            end
            if (exp[i] == 4'd9) begin
                total++;
                if ({ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW} !== {1'b0, 2'b01, 2'b10, 1'b0, 1'b0}) begin
                    bad++; $display("FAIL br_ctrl: got A=%b B=%b Res=%b RegW=%b MemW=%b expected 0 01 10 0 0",
                        ALUSrcA, ALUSrcB, ResultSrc, RegW, MemW);
                end
            end
        end
    endtask

    // Immediate data-processing; Op/Funct are disturbed in EXECUTEI and must be ignored.
    task automatic test_dp_imm_op_change();
        logic [3:0] exp [5];
        exp = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
        Op = 2'b00; Funct = 6'b100000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL dpi_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            if (exp[i] == 4'd7) begin
                total++;
                if ({ALUOp, ALUSrcA, ALUSrcB} !== {1'b1, 1'b0, 2'b01}) begin
                    bad++; $display("FAIL dpi_exec_ctrl: got ALUOp=%b A=%b B=%b expected 1 0 01", ALUOp, ALUSrcA, ALUSrcB);
                end
                Op = 2'b01; Funct = 6'b000001;
            end
        end
    endtask

    task automatic test_undef();
        logic [3:0] exp [3];
        exp = '{4'd0, 4'd1, 4'd0};
        Op = 2'b11; Funct = 6'b100001;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL undef_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
            total++;
            if ({RegW, MemW, Branch} !== 3'b000) begin
                bad++; $display("FAIL undef_writes[%0d]: got %b expected 000", i, {RegW, MemW, Branch});
            end
        end
    endtask

    // Store interrupted by an asynchronous reset while in MEMWRITE.
    task automatic test_reset_mid();
        Op = 2'b01; Funct = 6'b000000;
        repeat (3) @(negedge clk);
        total++;
        if ({State, MemW} !== {4'd5, 1'b1}) begin
            bad++; $display("FAIL rstmid_pre: got State=%0d MemW=%b expected 5 1", State, MemW);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({State, MemW, RegW, IRWrite} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            bad++; $display("FAIL rstmid_async: got State=%0d MemW=%b RegW=%b IRW=%b expected 0 0 0 1",
                State, MemW, RegW, IRWrite);
        end
        @(negedge clk);
        total++;
        if (State !== 4'd0) begin
            bad++; $display("FAIL rstmid_hold: got %0d expected 0", State);
        end
        reset = 1'b0;
        Op = 2'b11;
        @(negedge clk);
        total++;
        if ({State, RegW, MemW} !== {4'd1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rstmid_first_edge: got State=%0d RegW=%b MemW=%b expected 1 0 0", State, RegW, MemW);
        end
        @(negedge clk);
        total++;
        if ({State, RegW, MemW} !== {4'd0, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rstmid_after: got State=%0d RegW=%b MemW=%b expected 0 0 0", State, RegW, MemW);
        end
    endtask

    // Op changes during FETCH, before DECODE samples it, must take effect.
    task automatic test_back_to_back();
        logic [3:0] exp [4];
        exp = '{4'd0, 4'd1, 4'd9, 4'd0};
        Op = 2'b00; Funct = 6'b000000;
        #2;
        Op = 2'b10;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            total++;
            if (State !== exp[i]) begin
                bad++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, State, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dp_reg();
        test_load();
        test_store();
        test_branch();
        test_dp_imm_op_change();
        test_undef();
        test_back_to_back();
        test_reset_mid();
        test_undef();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
